// File: rtl/temp_sequencer.sv
// rtl/temp_sequencer.sv - instruction micro-sequencer; optional single-step gate via SEQ_SINGLE_STEP_EN
module temp_sequencer #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       zero,
  input  logic       memReady,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       memRead,
  output logic       memWrite,
  output logic       addrSel,
  output logic       WEir,
  output logic       pcInc,
  output logic       WEpc,
  output logic       WEtemp,
  output logic       WEacc,
  output logic       accSrc,
  output logic [1:0] aluOp,
  output logic       halted,
  output logic       error
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPFETCH = 3'd2,
    S_EXECUTE = 3'd3,
    S_STORE   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Last tolerated count: a low memReady seen here is the WAIT_MAX-th wait and times out.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             error_q, error_d;
  logic             fetch_go;
  logic             timeout;
  logic [3:0]       opcode;
  logic             unused_operand;

  logic mem_read_c, mem_write_c, addr_sel_c, we_ir_c, pc_inc_c;
  logic we_pc_c, we_temp_c, we_acc_c, acc_src_c;
  logic [1:0] alu_op_c;

  assign opcode         = ir[7:4];
  assign unused_operand = ^ir[3:0];
  assign timeout        = !memReady && (wait_cnt_q == WAIT_LAST);

`ifdef SEQ_SINGLE_STEP_EN
  logic step_ok_q, step_ok_d;

  // Fetch is armed by a sampled step and disarmed whenever FETCH is left.
  assign step_ok_d = (state_q == S_FETCH) && (state_d == S_FETCH) && (step_ok_q || step);
  assign fetch_go  = step_ok_q;

  // Single-step arm flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_ok_q <= 1'b0;
    end else begin
      step_ok_q <= step_ok_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // Next state, wait counter and datapath strobes decoded from state, ir, zero and memReady
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    error_d     = error_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    addr_sel_c  = 1'b0;
    we_ir_c     = 1'b0;
    pc_inc_c    = 1'b0;
    we_pc_c     = 1'b0;
    we_temp_c   = 1'b0;
    we_acc_c    = 1'b0;
    acc_src_c   = 1'b0;
    alu_op_c    = 2'b00;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          if (memReady) begin
            mem_read_c = 1'b1;
            we_ir_c    = 1'b1;
            pc_inc_c   = 1'b1;
            state_d    = S_DECODE;
          end else if (timeout) begin
            error_d = 1'b1;
            state_d = S_HALT;
          end else begin
            mem_read_c = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_ONE;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_OPFETCH;
          OP_STA: state_d = S_STORE;
          OP_JMP: begin
            we_pc_c = 1'b1;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            we_pc_c = zero;
            state_d = S_FETCH;
          end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_OPFETCH: begin
        if (memReady) begin
          mem_read_c = 1'b1;
          addr_sel_c = 1'b1;
          if (opcode == OP_LDA) begin
            we_acc_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            we_temp_c = 1'b1;
            state_d   = S_EXECUTE;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_read_c = 1'b1;
          addr_sel_c = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_EXECUTE: begin
        we_acc_c  = 1'b1;
        acc_src_c = 1'b1;
        alu_op_c  = 2'(opcode - 4'd3);
        state_d   = S_FETCH;
      end
      S_STORE: begin
        if (memReady) begin
          mem_write_c = 1'b1;
          addr_sel_c  = 1'b1;
          state_d     = S_FETCH;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_write_c = 1'b1;
          addr_sel_c  = 1'b1;
          wait_cnt_d  = wait_cnt_q + CNT_ONE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign memRead  = mem_read_c  & ~reset;
  assign memWrite = mem_write_c & ~reset;
  assign addrSel  = addr_sel_c  & ~reset;
  assign WEir     = we_ir_c     & ~reset;
  assign pcInc    = pc_inc_c    & ~reset;
  assign WEpc     = we_pc_c     & ~reset;
  assign WEtemp   = we_temp_c   & ~reset;
  assign WEacc    = we_acc_c    & ~reset;
  assign accSrc   = acc_src_c   & ~reset;
  assign aluOp    = reset ? 2'b00 : alu_op_c;
  assign halted   = (state_q == S_HALT) & ~reset;
  assign error    = error_q & ~reset;

endmodule

// File: tb/tb_temp_sequencer.sv
// tb/tb_temp_sequencer.sv - randomized self-checking bench for temp_sequencer
`timescale 1ns/1ps
module tb_temp_sequencer;
  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ir = 8'h00;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       step_drv = 1'b0;
  logic       memRead, memWrite, addrSel, WEir, pcInc, WEpc, WEtemp, WEacc, accSrc;
  logic [1:0] aluOp;
  logic       halted, error;

  temp_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ir(ir), .zero(zero), .memReady(memReady),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step_drv),
`endif
    .memRead(memRead), .memWrite(memWrite), .addrSel(addrSel), .WEir(WEir),
    .pcInc(pcInc), .WEpc(WEpc), .WEtemp(WEtemp), .WEacc(WEacc), .accSrc(accSrc),
    .aluOp(aluOp), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // Observed output bundle: rd wr asel wir pci wpc wt wa src alu[1:0] h e
  typedef struct packed {
    logic rd; logic wr; logic asel; logic wir; logic pci; logic wpc;
    logic wt; logic wa; logic src; logic [1:0] alu; logic h; logic e;
  } ov_t;

  typedef struct {
    logic [7:0] ir; logic z; logic rdy; logic stp; ov_t exp;
  } cyc_t;

  ov_t  cur;
  cyc_t plan[$];
  ov_t  act[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   halted_m, error_m;

  assign cur = {memRead, memWrite, addrSel, WEir, pcInc, WEpc, WEtemp, WEacc, accSrc, aluOp, halted, error};

  function automatic logic rb();
    return ($urandom_range(0, 1) != 0);
  endfunction

  function automatic ov_t mk(input logic [8:0] bits, input logic [1:0] alu);
    ov_t v;
    v = {bits, alu, 2'b00};
    return v;
  endfunction

  function automatic ov_t halt_vec(input bit e);
    ov_t v;
    v = '0;
    v.h = 1'b1;
    v.e = e;
    return v;
  endfunction

  task automatic push(input logic [7:0] i, input logic z, input logic rdy, input logic stp, input ov_t e);
    cyc_t c;
    c.ir = i; c.z = z; c.rdy = rdy; c.stp = stp; c.exp = e;
    plan.push_back(c);
  endtask

  // One memory access: up to WAIT_MAX-1 waits are tolerated, the WAIT_MAX-th low cycle is a silent timeout.
  task automatic model_access(input logic [7:0] i, input logic z, input bit is_wr, input bit asel,
                              input int waits, output bit ok);
    ov_t req;
    int  n;
    req = mk({~is_wr, is_wr, asel, 6'b000000}, 2'b00);
    n = (waits >= WAIT_MAX) ? WAIT_MAX - 1 : waits;
    for (int k = 0; k < n; k++) push(i, z, 1'b0, rb(), req);
    if (waits >= WAIT_MAX) begin
      push(i, z, 1'b0, rb(), ov_t'(0));
      halted_m = 1'b1;
      error_m  = 1'b1;
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
  endtask

  // Instruction-level reference: fetch access, decode cycle, optional operand access and execute cycle.
  task automatic model_instr(input logic [7:0] i, input logic z, input int wf, input int wo, input int gate);
    bit         ok;
    logic [3:0] op;
    logic [1:0] alu;
    op = i[7:4];
    if (halted_m) return;
`ifdef SEQ_SINGLE_STEP_EN
    for (int g = 0; g < gate; g++) push(i, z, rb(), 1'b0, ov_t'(0));
    push(i, z, rb(), 1'b1, ov_t'(0));
`endif
    model_access(i, z, 1'b0, 1'b0, wf, ok);
    if (!ok) return;
    push(i, z, 1'b1, rb(), mk(9'b100110000, 2'b00));
    case (op)
      4'h7: push(i, z, rb(), rb(), mk(9'b000001000, 2'b00));
      4'h8: push(i, z, rb(), rb(), mk({5'b00000, z, 3'b000}, 2'b00));
      4'hF: begin
        push(i, z, rb(), rb(), ov_t'(0));
        halted_m = 1'b1;
      end
      4'h2: begin
        push(i, z, rb(), rb(), ov_t'(0));
        model_access(i, z, 1'b1, 1'b1, wo, ok);
        if (ok) push(i, z, 1'b1, rb(), mk(9'b011000000, 2'b00));
      end
      4'h1: begin
        push(i, z, rb(), rb(), ov_t'(0));
        model_access(i, z, 1'b0, 1'b1, wo, ok);
        if (ok) push(i, z, 1'b1, rb(), mk(9'b101000010, 2'b00));
      end
      4'h3, 4'h4, 4'h5, 4'h6: begin
        case (op)
          4'h3: alu = 2'b00;
          4'h4: alu = 2'b01;
          4'h5: alu = 2'b10;
          default: alu = 2'b11;
        endcase
        push(i, z, rb(), rb(), ov_t'(0));
        model_access(i, z, 1'b0, 1'b1, wo, ok);
        if (ok) begin
          push(i, z, 1'b1, rb(), mk(9'b101000100, 2'b00));
          push(i, z, rb(), rb(), mk(9'b000000011, alu));
        end
      end
      default: push(i, z, rb(), rb(), ov_t'(0));
    endcase
  endtask

  task automatic model_halt(input int n);
    for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)), rb(), rb(), rb(), halt_vec(error_m));
  endtask

  // Applies the first n planned cycles (all if n < 0) and records the outputs of each.
  task automatic run_plan(input int n);
    int lim;
    lim = (n < 0 || n > plan.size()) ? plan.size() : n;
    act.delete();
    for (int k = 0; k < lim; k++) begin
      ir = plan[k].ir; zero = plan[k].z; memReady = plan[k].rdy; step_drv = plan[k].stp;
      #2;
      act.push_back(cur);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; memReady = 1'b0; step_drv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    plan.delete();
    halted_m = 1'b0;
    error_m  = 1'b0;
  endtask

  task automatic test_reset();
    ov_t want;
    do_reset();
    model_instr(8'h35, 1'b0, 0, 6, 2);
    run_plan(plan.size() - 3);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL reset_pre cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
    memReady = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (cur !== ov_t'(0)) begin
      miscompares++;
      $display("FAIL reset_async: got %b want %b", cur, ov_t'(0));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (cur !== ov_t'(0)) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", cur, ov_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
`ifdef SEQ_SINGLE_STEP_EN
    want = ov_t'(0);
`else
    want = mk(9'b100000000, 2'b00);
`endif
    vectors++;
    if (cur !== want) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", cur, want);
    end
    plan.delete();
    halted_m = 1'b0;
    error_m  = 1'b0;
    model_instr(8'h00, 1'b0, 1, 0, 1);
    model_instr(8'h35, 1'b1, 0, 0, 0);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL reset_post cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
  endtask

  task automatic test_sub();
    int wt_cnt;
    do_reset();
    model_instr(8'h47, 1'b0, 0, 0, 0);
    model_instr(8'h00, 1'b0, 0, 0, 0);
    run_plan(-1);
    wt_cnt = 0;
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k].wt === 1'b1) wt_cnt++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL sub cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
    vectors++;
    if (wt_cnt !== 1) begin
      miscompares++;
      $display("FAIL sub_wetemp_count: got %0d want 1", wt_cnt);
    end
  endtask

  task automatic test_jumps();
    do_reset();
    model_instr(8'h8A, 1'b0, 0, 0, 0);
    model_instr(8'h8A, 1'b1, 0, 0, 1);
    model_instr(8'h7C, 1'b0, 2, 0, 0);
    model_instr(8'h9B, 1'b1, 0, 0, 0);
    model_instr(8'h00, 1'b0, 0, 0, 0);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL jumps cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    model_instr(8'h23, 1'b0, 0, 3, 0);
    model_instr(8'h1E, 1'b0, 1, 2, 0);
    model_instr(8'h00, 1'b0, 0, 0, 0);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL store cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    model_instr(8'h11, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1, 0);
    model_instr(8'h25, 1'b0, 0, WAIT_MAX - 1, 0);
    model_instr(8'h52, 1'b0, 0, WAIT_MAX, 0);
    model_halt(4);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL timeout_op cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
    do_reset();
    model_instr(8'h10, 1'b0, WAIT_MAX, 0, 0);
    model_halt(5);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL timeout_fetch cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
    do_reset();
    model_instr(8'h00, 1'b0, 0, 0, 0);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL timeout_clear cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    model_instr(8'hF0, 1'b0, 0, 0, 3);
    model_halt(6);
    run_plan(-1);
    for (int k = 0; k < act.size(); k++) begin
      vectors++;
      if (act[k] !== plan[k].exp) begin
        miscompares++;
        $display("FAIL halt cyc%0d: got %b want %b", k, act[k], plan[k].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] i;
    int         wf, wo;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        i = 8'($urandom_range(0, 255));
        if (i[7:4] == 4'hF) i[7:4] = 4'h0;
        wf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WAIT_MAX - 1)) : int'($urandom_range(0, 2));
        wo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WAIT_MAX - 1)) : int'($urandom_range(0, 2));
        model_instr(i, rb(), wf, wo, int'($urandom_range(0, 2)));
      end
      model_instr(8'hF3, 1'b0, 0, 0, 0);
      model_halt(3);
      run_plan(-1);
      for (int k = 0; k < act.size(); k++) begin
        vectors++;
        if (act[k] !== plan[k].exp) begin
          miscompares++;
          $display("FAIL b2b r%0d cyc%0d: got %b want %b", r, k, act[k], plan[k].exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_jumps();
    test_store();
    test_timeout();
    test_halt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
